alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that performs mulq (64x64 -> low 64-bit product) by sequencing the shared execute-stage ALU through shift-add iterations.
- Sits beside the execute stage. It owns the ALU's func/X/Y inputs while busy and returns the result with condition flags zf/sf/of.
- Uses start/busy/done handshake; one ALU add per cycle.

Parameters:
WIDTH, 64, operand/result width; also number of RUN iterations
CNT_W, 7, iteration counter width; must hold WIDTH-1

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE
op_a  input  WIDTH  multiplicand, latched on accepted start
op_b  input  WIDTH  multiplier, latched on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse in DONE state
result  output  WIDTH  product low WIDTH bits; held until next accepted start
zf  output  1  result == 0, updated in DONE
sf  output  1  result[WIDTH-1], updated in DONE
of  output  1  sticky OR of alu_ovf over accumulate steps, updated in DONE
alu_func  output  2  ALU function select; 2'b00 = add
alu_x  output  WIDTH  ALU operand X
alu_y  output  WIDTH  ALU operand Y
alu_z  input  WIDTH  ALU result (combinational from alu_x/alu_y)
alu_ovf  input  1  ALU signed-overflow flag for current operation

Behaviour:
- Reset (rst_n=0, async): state=IDLE; acc, mcand, mplier, cnt, result = 0; busy, done, zf, sf, of, of_acc = 0.
- Reset takes effect immediately, including mid-RUN; the in-flight operation is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at posedge:
  - mcand <= op_a; mplier <= op_b; acc <= 0; cnt <= 0; of_acc <= 0.
  - Go to RUN.
  - result and flags are unchanged until DONE.
- RUN, each cycle:
  - Drive alu_func=00, alu_x=acc, alu_y=mcand.
  - At posedge, if mplier[0]=1: acc <= alu_z and of_acc <= of_acc | alu_ovf.
  - mcand <= mcand << 1 (zero fill); mplier <= mplier >> 1 (logical); cnt <= cnt+1.
  - If cnt == WIDTH-1, go to DONE.
- DONE, one cycle:
  - done=1; result=acc; zf=(acc==0); sf=acc[WIDTH-1]; of=of_acc. These are registered so they are visible during the DONE cycle.
  - Next state is IDLE unconditionally.
- Outside RUN: alu_func=00, alu_x=0, alu_y=0.
- Latency: start accepted at edge E0; done high in the cycle following edge E0+WIDTH, i.e. WIDTH+1 cycles after acceptance. With WIDTH=64, done is in cycle 65.
- start while busy (RUN or DONE): ignored, no queueing. Back-to-back operation requires start in IDLE, giving a minimum issue interval of WIDTH+2 cycles.
- Arithmetic is modulo 2^WIDTH. The low product is correct for both signed and unsigned operands.
- mcand bits shifted out are lost and do not set of. of reflects ALU add overflow only.
- op_a/op_b changes after acceptance have no effect.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined: in RUN, go to DONE when cnt == WIDTH-1 or when the next mplier (mplier>>1) == 0.
  - op_b=0 takes one RUN cycle.
  - op_b=5 takes 3 RUN cycles, so done is 4 cycles after acceptance.
  - Results and flags are identical to the non-early path.
- Undefined: always WIDTH RUN cycles.

Test Plan:
- op_a=6, op_b=7, start -> busy=1 next cycle; done exactly 65 cycles after acceptance; result=42, zf=0, sf=0, of=0.
- op_a=-3 (0xFFFF_FFFF_FFFF_FFFD), op_b=5 -> result=0xFFFF_FFFF_FFFF_FFF1 (-15), sf=1, zf=0, of=0.
- op_a=0x1234, op_b=0 -> result=0, zf=1, sf=0. With MUL_EARLY_TERM_EN, done 2 cycles after acceptance.
- op_a=0x3000_0000_0000_0000, op_b=3 -> result=0x9000_0000_0000_0000, of=1, sf=1.
- Accept 6*7, pulse start with op_a=2, op_b=2 during RUN and again in DONE -> both ignored; single done; result=42; busy falls after DONE.
- Accept 6*7, drop rst_n at cycle 30 for 2 cycles -> busy, done, result, flags = 0 immediately. Then start 2*3 -> result=6 after full latency.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
//------------------------------------------------------------------------------
// Module   : alu_mul_sequencer
// Brief    : Computes the low WIDTH bits of a WIDTH x WIDTH product (mulq).
//            It steers the shared execute-stage ALU through one shift-add
//            step per cycle and reports zf/sf/of with the result.
//            Optional macro MUL_EARLY_TERM_EN stops the loop early once no
//            set multiplier bits remain.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic [1:0]       alu_func,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_ovf
);

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);
  localparam logic [1:0]       c_func_add = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             r_of_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_zf;
  logic             r_sf;
  logic             r_of;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_acc_next;
  logic             w_of_next;
  logic             w_last_iter;

  // Accumulate only when the current multiplier bit selects the shifted multiplicand.
  assign w_acc_next = r_mplier[0] ? alu_z : r_acc;
  assign w_of_next  = r_of_acc | (r_mplier[0] & alu_ovf);

`ifdef MUL_EARLY_TERM_EN
  // Stop as soon as the remaining multiplier has no set bits; further adds would be no-ops.
  assign w_last_iter = (r_cnt == c_last_cnt) || (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_last_iter = (r_cnt == c_last_cnt);
`endif

  // The ALU is driven only while iterating; otherwise it sees an idle add of zeros.
  assign alu_func = c_func_add;
  assign alu_x    = (r_state == S_RUN) ? r_acc   : '0;
  assign alu_y    = (r_state == S_RUN) ? r_mcand : '0;

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign zf     = r_zf;
  assign sf     = r_sf;
  assign of     = r_of;

  // Sequencer FSM with datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_of_acc <= 1'b0;
      r_result <= '0;
      r_zf     <= 1'b0;
      r_sf     <= 1'b0;
      r_of     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_of_acc <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end

        S_RUN: begin
          r_acc    <= w_acc_next;
          r_of_acc <= w_of_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last_iter) begin
            // Capture the final step's sum directly so the result is valid while done is high.
            r_result <= w_acc_next;
            r_zf     <= (w_acc_next == '0);
            r_sf     <= w_acc_next[WIDTH-1];
            r_of     <= w_of_next;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_mul_sequencer
// Brief    : Self-checking bench for alu_mul_sequencer with an ALU model,
//            a directed vector table, random vectors and handshake sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_mul_sequencer;

  localparam int WIDTH = 64;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             sf;
  logic             of;
  logic [1:0]       alu_func;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] alu_z;
  logic             alu_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .zf(zf), .sf(sf), .of(of),
    .alu_func(alu_func), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
    .alu_ovf(alu_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Execute-stage ALU: add with signed overflow detection.
  always_comb begin
    alu_z   = alu_x + alu_y;
    alu_ovf = (alu_x[WIDTH-1] == alu_y[WIDTH-1]) && (alu_z[WIDTH-1] != alu_x[WIDTH-1]);
  end

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             zf;
    logic             sf;
    logic             of;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: product by plain multiplication; of from the partial-sum adds.
  task automatic ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           output logic [WIDTH-1:0] r, output logic ovf);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] nxt;
    sum = '0;
    ovf = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) begin
        term = a << i;
        nxt  = sum + term;
        if ((sum[WIDTH-1] == term[WIDTH-1]) && (nxt[WIDTH-1] != sum[WIDTH-1])) ovf = 1'b1;
        sum = nxt;
      end
    end
    r = a * b;
  endtask

  function automatic int exp_latency(input logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    int runs;
    runs = 1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) runs = i + 1;
    return runs + 1;
`else
    return WIDTH + 1;
`endif
  endfunction

  // Issue one operation at a negedge and check latency, ALU drive, result and flags.
  task automatic run_op(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] er, input logic ezf, input logic esf,
                        input logic eof);
    int cycles;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    op_a   = {$urandom, $urandom};
    op_b   = {$urandom, $urandom};
    cycles = 1;
    chk({nm, " busy_after_accept"}, 64'(busy), 64'd1);
    chk({nm, " alu_y_first_step"}, alu_y, a);
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    chk({nm, " latency"}, 64'(cycles), 64'(exp_latency(b)));
    chk({nm, " result"}, result, er);
    chk({nm, " flags zf/sf/of"}, {61'd0, zf, sf, of}, {61'd0, ezf, esf, eof});
    @(negedge clk);
    chk({nm, " idle after done"}, {62'd0, busy, done}, 64'd0);
    chk({nm, " result held"}, result, er);
    chk({nm, " alu idle"}, alu_x | alu_y, 64'd0);
  endtask

  initial begin
    int dcount;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rr;
    logic             rof;

    vecs[0] = '{64'd6, 64'd7, 64'd42, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{64'h1234, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{64'h3000_0000_0000_0000, 64'd3, 64'h9000_0000_0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #2;
    chk("reset outputs", {58'd0, busy, done, zf, sf, of, 1'b0}, 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset alu", alu_x | alu_y | {62'd0, alu_func}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].zf, vecs[i].sf, vecs[i].of);

    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 4 == 1) rb = 64'($urandom_range(0, 255));
      if (i % 4 == 2) rb = rb >> $urandom_range(0, 63);
      ref_model(ra, rb, rr, rof);
      run_op($sformatf("rand%0d", i), ra, rb, rr, (rr == 0), rr[WIDTH-1], rof);
    end

    // start pulses during RUN and DONE must be ignored.
    op_a  = 64'd6;
    op_b  = 64'd7;
    start = 1'b1;
    @(negedge clk);
    op_a  = 64'd2;
    op_b  = 64'd2;
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    for (int c = 0; c < 200 && !done; c++) @(negedge clk);
    chk("ignore done seen", 64'(done), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignore busy falls", {62'd0, busy, done}, 64'd0);
    chk("ignore result", result, 64'd42);
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("ignore no second op", 64'(dcount), 64'd0);

    // Asynchronous reset mid-RUN clears everything and suppresses done.
    op_a  = 64'd6;
    op_b  = 64'd7;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    repeat (29) begin
      @(negedge clk);
      if (done) dcount++;
    end
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", {59'd0, busy, done, zf, sf, of}, 64'd0);
    chk("async reset result", result, 64'd0);
    repeat (2) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("reset no done", 64'(dcount), 64'd0);
    run_op("after reset", 64'd2, 64'd3, 64'd6, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
